// File: rtl/factor_search.sv
// factor_search: trial-division factoriser. Finds the smallest divisor i2 >= 2
// of `a` (with i2*i2 <= a) and its cofactor i1 = a / i2, testing each candidate
// with a WIDTH-cycle restoring divider.
module factor_search #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] i2
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCheck, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  cand_q, cand_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic [WIDTH-1:0]  i1_q, i1_d;
  logic [WIDTH-1:0]  i2_q, i2_d;

  // Divider datapath and square test, evaluated every cycle.
  logic [2*WIDTH-1:0] square;
  logic [2*WIDTH-1:0] a_ext;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  // One restoring-division step plus the full-width cand*cand compare.
  always_comb begin
    square = {{WIDTH{1'b0}}, cand_q} * {{WIDTH{1'b0}}, cand_q};
    a_ext  = {{WIDTH{1'b0}}, a_q};
    // rem stays below cand, so one extra bit holds the shifted value.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    rem_nx = rem_sh;
    if (rem_sh >= {1'b0, cand_q}) begin
      rem_nx    = rem_sh - {1'b0, cand_q};
      quo_nx[0] = 1'b1;
    end
  end

  // Next-state and output-register logic for the search FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cand_d  = cand_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          cand_d  = WIDTH'(2);
          found_d = 1'b0;
          i1_d    = '0;
          i2_d    = '0;
          busy_d  = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (square > a_ext) begin
          found_d = 1'b0;
          state_d = StDone;
        end else begin
          quo_d   = a_q;
          rem_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StDiv;
        end
      end
      StDiv: begin
        quo_d = quo_nx;
        rem_d = rem_nx[WIDTH-1:0];
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          if (rem_nx == '0) begin
            found_d = 1'b1;
            i1_d    = quo_nx;
            i2_d    = cand_q;
            state_d = StDone;
          end else begin
            cand_d  = cand_q + WIDTH'(1);
            state_d = StCheck;
          end
        end
      end
      StDone: begin
        // done and busy are registered, so they change on the exit edge.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      cand_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      i1_q    <= '0;
      i2_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cand_q  <= cand_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign i1    = i1_q;
  assign i2    = i2_q;

endmodule

// File: tb/tb_factor_search.sv
// Self-checking bench for factor_search: directed boundary cases, ignored
// starts, mid-search reset and random values against a trial-division model.
module tb_factor_search;

  localparam int unsigned WIDTH = 10;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;

  int n_vec;
  int n_err;

  factor_search #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .found (found),
    .i1    (i1),
    .i2    (i2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: smallest divisor by plain trial division, latency from the
  // number of candidates that reach the divider.
  task automatic model(input int av, output int f, output int m1, output int m2,
                       output int lat);
    int k;
    f  = 0;
    m1 = 0;
    m2 = 0;
    k  = 0;
    for (int d = 2; d * d <= av; d++) begin
      k++;
      if (av % d == 0) begin
        f  = 1;
        m1 = av / d;
        m2 = d;
        break;
      end
    end
    lat = f ? (WIDTH + 1) * k + 1 : (WIDTH + 1) * k + 2;
  endtask

  // Runs one search; if poke >= 0 a start with a=6 is pulsed after that cycle.
  task automatic run(input int av, input int poke);
    int ef, e1, e2, elat, cyc;
    bit got_done;
    model(av, ef, e1, e2, elat);
    @(negedge clk);
    start = 1'b1;
    a     = WIDTH'(av);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("busy_after_accept a=%0d", av), int'(busy), 1);
    cyc      = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      if (cyc == poke) begin
        start = 1'b1;
        a     = WIDTH'(6);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check($sformatf("latency a=%0d", av), got_done ? cyc : -1, elat);
    check($sformatf("found a=%0d", av), int'(found), ef);
    check($sformatf("i1 a=%0d", av), int'(i1), e1);
    check($sformatf("i2 a=%0d", av), int'(i2), e2);
    check($sformatf("busy_at_done a=%0d", av), int'(busy), 0);
    // Checker view: found iff (i1, i2, a) is a non-trivial factorisation.
    check($sformatf("checker a=%0d", av), int'(found),
          int'((int'(i1) * int'(i2) == av) && (i2 >= 2) && (i1 >= i2)));
    @(negedge clk);
    check($sformatf("done_pulse a=%0d", av), int'(done), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset found", int'(found), 0);
    check("reset i1", int'(i1), 0);
    check("reset i2", int'(i2), 0);
    rst_n = 1'b1;

    // Directed cases.
    run(15, -1);
    run(13, -1);
    run(4, -1);
    run(0, -1);
    run(1, -1);
    run(2, -1);
    run(3, -1);
    run(1023, -1);
    run(1021, -1);

    // Start pulses during DIV and during DONE must be ignored.
    run(13, 3);
    run(13, 23);

    // Reset in the middle of an a=15 search.
    @(negedge clk);
    start = 1'b1;
    a     = WIDTH'(15);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset found", int'(found), 0);
    check("midreset i1", int'(i1), 0);
    check("midreset i2", int'(i2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle after reset busy", int'(busy), 0);
    run(15, -1);

    // Random values across the full input range.
    for (int n = 0; n < 40; n++) begin
      run(int'($urandom_range(0, (1 << WIDTH) - 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
